soc_bbox_extract: RTL
=====================

// Module: soc_bbox_extract
// PURPOSE
//  Consumes the binary foreground-mask pixel stream from the segmentation stage, one pixel per beat.
//  Computes the per-frame bounding box and foreground pixel count, then packs them into one 32-bit status word.
//  That word drives the in_port of the bbox PIO; bit 31 rises once per frame, so the PIO edge-capture raises an IRQ per frame.
// PARAMETERS
//  IMG_W    640  active pixels per line
//  IMG_H    480  active lines per frame
//  SHIFT    2    right-shift applied to coordinates before packing; (IMG_W-1)>>SHIFT must fit 8b, (IMG_H-1)>>SHIFT must fit 7b
//  MIN_PIX  64   minimum foreground count for found=1
//  CNT_W    20   pixel-counter width, saturating; must hold IMG_W*IMG_H
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   reset, asynchronous, active-low
//  sink_valid   in   1   pixel beat valid
//  sink_ready   out  1   0 in reset, 1 otherwise (no backpressure)
//  sink_data    in   1   mask pixel, 1 = foreground
//  sink_sop     in   1   first pixel of frame, qualified by sink_valid
//  sink_eop     in   1   last pixel of frame, qualified by sink_valid
//  bbox_word    out  32  [31] frame_done, [30] found, [29:22] xmin, [21:14] xmax, [13:7] ymin, [6:0] ymax
//  pix_count    out  CNT_W  foreground count of last published frame
//  frame_err    out  1   one-cycle pulse on a discarded frame
// BEHAVIOUR
//  Reset: bbox_word=0, pix_count=0, frame_err=0, state IDLE, all counters 0.
//  Beat = sink_valid & sink_ready. Non-valid cycles are ignored everywhere.
//  FSM IDLE: beat with sop -> ACTIVE; that beat is pixel (0,0). Beats without sop are dropped silently.
//  FSM ACTIVE: x increments per beat; at x==IMG_W-1, x wraps to 0 and y increments.
//    On a foreground beat: xmin=min(xmin,x), xmax=max, same for y; count +1, saturating at all-ones.
//    Accumulators start at xmin=IMG_W-1, xmax=0, ymin=IMG_H-1, ymax=0 on the sop beat, before that pixel is applied.
//  Beat with eop in ACTIVE, and it is pixel (IMG_W-1,IMG_H-1) -> PUBLISH; any other position -> ERR.
//  Beat with sop in ACTIVE (or in ERR/PUBLISH) -> restart the frame on that beat. The old frame raises frame_err and is not published.
//  Beat at (IMG_W-1,IMG_H-1) without eop -> ERR (overlong frame). Further beats are ignored until the next sop.
//  PUBLISH (1 cycle):
//    bbox_word[31]=1, found=(count>=MIN_PIX), coordinate fields = acc>>SHIFT, pix_count=count.
//    If found=0, all four coordinate fields are 0.
//    Next cycle: [31]=0; fields [30:0] and pix_count hold until the next PUBLISH. Return to IDLE.
//  ERR (1 cycle): frame_err=1; bbox_word and pix_count unchanged -> IDLE.
//  Latency: eop beat at cycle N -> bbox_word[31]=1 during cycle N+1 only. An sop beat at N+1 is accepted (back-to-back frames).
//  Asynchronous reset mid-frame: all state cleared; the partial frame is never published.
//  Constraint: bit 31 high for exactly 1 cycle, never 2 consecutive cycles. This guarantees exactly one PIO edge per frame.
// STRUCTURE
//  Shared package soc_bbox_pkg:
//    field offsets and widths (FRAME_DONE_BIT=31, FOUND_BIT=30, XMIN_LSB=22, XMAX_LSB=14, YMIN_LSB=7, YMAX_LSB=0)
//    FSM state encoding (IDLE, ACTIVE, PUBLISH, ERR)
//  Sub-module bbox_minmax_acc #(W):
//    ports clk, reset_n, init, en, value[W-1:0], min_o, max_o; init loads min=all-ones-of-range, max=0
//    instantiated twice, for x and y.
//  Top level holds the FSM, x/y counters, pixel counter and output packing.
// TESTING (bench overrides IMG_W=16, IMG_H=8, SHIFT=0, MIN_PIX=2)
//  1. Frame with foreground only at (3,2),(10,5) -> one cycle after eop: bbox_word[31]=1, found=1, xmin=3, xmax=10, ymin=2, ymax=5, pix_count=2; next cycle [31]=0, fields held.
//  2. All-zero frame -> found=0, coordinate fields=0, pix_count=0, [31] pulses once.
//  3. Single foreground pixel at (15,7), MIN_PIX=2 -> found=0, pix_count=1, fields 0. Same frame with MIN_PIX=1 -> xmin=xmax=15, ymin=ymax=7.
//  4. eop after 100 beats -> frame_err pulse, no [31] pulse, previous bbox_word unchanged. sop inside a frame -> frame_err, and the new frame publishes correctly.
//  5. Two back-to-back frames, sop on the cycle after eop, plus random sink_valid gaps -> two [31] pulses with correct independent results.
//  6. reset_n low mid-frame, then a full frame -> outputs 0 during reset, one correct publish after; never two consecutive cycles with [31]=1.

Source files
------------

// File: rtl/soc_bbox_pkg.sv
// Shared definitions for the bounding-box extractor: status-word layout,
// FSM encoding and the status-word packing helper.
package soc_bbox_pkg;

    localparam int FRAME_DONE_BIT = 31;
    localparam int FOUND_BIT      = 30;
    localparam int XMIN_LSB       = 22;
    localparam int XMAX_LSB       = 14;
    localparam int YMIN_LSB       = 7;
    localparam int YMAX_LSB       = 0;
    localparam int XF_W           = 8;
    localparam int YF_W           = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        PUBLISH = 2'd2,
        ERR     = 2'd3
    } bbox_state_e;

    // Coordinate fields are forced to zero when no object was found.
    function automatic logic [31:0] pack_bbox(input logic found,
                                              input logic [XF_W-1:0] xmin,
                                              input logic [XF_W-1:0] xmax,
                                              input logic [YF_W-1:0] ymin,
                                              input logic [YF_W-1:0] ymax);
        logic [31:0] w;
        w                       = 32'd0;
        w[FRAME_DONE_BIT]       = 1'b1;
        w[FOUND_BIT]            = found;
        w[XMIN_LSB +: XF_W]     = found ? xmin : 8'd0;
        w[XMAX_LSB +: XF_W]     = found ? xmax : 8'd0;
        w[YMIN_LSB +: YF_W]     = found ? ymin : 7'd0;
        w[YMAX_LSB +: YF_W]     = found ? ymax : 7'd0;
        return w;
    endfunction

endpackage

// File: rtl/soc_bbox_extract_acc.sv
// Running min/max tracker for one coordinate axis; init restarts the range
// and applies the current value in the same cycle when en is also high.
module bbox_minmax_acc #(
    parameter int           W        = 4,
    parameter logic [W-1:0] INIT_MIN = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_init,
    input  logic         i_en,
    input  logic [W-1:0] i_value,
    output logic [W-1:0] o_min,
    output logic [W-1:0] o_max
);

    logic [W-1:0] r_min;
    logic [W-1:0] r_max;

    // Range registers: restart on init, otherwise widen on each enabled value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_min <= {W{1'b0}};
            r_max <= {W{1'b0}};
        end else if (i_init) begin
            r_min <= i_en ? i_value : INIT_MIN;
            r_max <= i_en ? i_value : {W{1'b0}};
        end else if (i_en) begin
            r_min <= (i_value < r_min) ? i_value : r_min;
            r_max <= (i_value > r_max) ? i_value : r_max;
        end
    end

    assign o_min = r_min;
    assign o_max = r_max;

endmodule

// File: rtl/soc_bbox_extract.sv
// Per-frame bounding box and foreground count from a binary mask stream,
// published as a 32-bit status word whose bit 31 pulses once per good frame.
module soc_bbox_extract
    import soc_bbox_pkg::*;
#(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int SHIFT   = 2,
    parameter int MIN_PIX = 64,
    parameter int CNT_W   = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_sink_valid,
    output logic             o_sink_ready,
    input  logic             i_sink_data,
    input  logic             i_sink_sop,
    input  logic             i_sink_eop,
    output logic [31:0]      o_bbox_word,
    output logic [CNT_W-1:0] o_pix_count,
    output logic             o_frame_err
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    bbox_state_e      r_state;
    logic             r_ready;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_bbox_word;
    logic [CNT_W-1:0] r_pix_count;
    logic             r_frame_err;

    logic             w_beat, w_start, w_frame_beat, w_fg;
    logic [XW-1:0]    w_px, w_nx, w_xmin, w_xmax, w_xmin_base, w_xmax_base, w_xmin_fin, w_xmax_fin;
    logic [YW-1:0]    w_py, w_ny, w_ymin, w_ymax, w_ymin_base, w_ymax_base, w_ymin_fin, w_ymax_fin;
    logic             w_x_wrap, w_last, w_found;
    logic [CNT_W-1:0] w_cnt_base, w_cnt_next;
    logic [31:0]      w_pub_word;

    // An sop beat is always pixel (0,0) of a fresh frame, whatever the state.
    assign w_beat       = i_sink_valid & r_ready;
    assign w_start      = w_beat & i_sink_sop;
    assign w_frame_beat = w_start | (w_beat & (r_state == ACTIVE));
    assign w_fg         = w_frame_beat & i_sink_data;
    assign w_px         = i_sink_sop ? {XW{1'b0}} : r_x;
    assign w_py         = i_sink_sop ? {YW{1'b0}} : r_y;
    assign w_x_wrap     = (w_px == X_LAST);
    assign w_last       = w_x_wrap & (w_py == Y_LAST);
    assign w_nx         = w_x_wrap ? {XW{1'b0}} : w_px + XW'(1);
    assign w_ny         = w_x_wrap ? w_py + YW'(1) : w_py;
    assign w_cnt_base   = i_sink_sop ? {CNT_W{1'b0}} : r_count;
    assign w_cnt_next   = (w_fg & ~&w_cnt_base) ? w_cnt_base + CNT_W'(1) : w_cnt_base;

    bbox_minmax_acc #(.W(XW), .INIT_MIN(X_LAST)) u_acc_x (
        .clk(clk), .reset_n(reset_n), .i_init(w_start), .i_en(w_fg),
        .i_value(w_px), .o_min(w_xmin), .o_max(w_xmax)
    );

    bbox_minmax_acc #(.W(YW), .INIT_MIN(Y_LAST)) u_acc_y (
        .clk(clk), .reset_n(reset_n), .i_init(w_start), .i_en(w_fg),
        .i_value(w_py), .o_min(w_ymin), .o_max(w_ymax)
    );

    // The eop pixel lands in the accumulators one cycle too late, so fold it in here.
    assign w_xmin_base = i_sink_sop ? X_LAST : w_xmin;
    assign w_xmax_base = i_sink_sop ? {XW{1'b0}} : w_xmax;
    assign w_ymin_base = i_sink_sop ? Y_LAST : w_ymin;
    assign w_ymax_base = i_sink_sop ? {YW{1'b0}} : w_ymax;
    assign w_xmin_fin  = (w_fg && (w_px < w_xmin_base)) ? w_px : w_xmin_base;
    assign w_xmax_fin  = (w_fg && (w_px > w_xmax_base)) ? w_px : w_xmax_base;
    assign w_ymin_fin  = (w_fg && (w_py < w_ymin_base)) ? w_py : w_ymin_base;
    assign w_ymax_fin  = (w_fg && (w_py > w_ymax_base)) ? w_py : w_ymax_base;
    assign w_found     = (w_cnt_next >= CNT_W'(MIN_PIX));
    assign w_pub_word  = pack_bbox(w_found,
                                   XF_W'(w_xmin_fin >> SHIFT), XF_W'(w_xmax_fin >> SHIFT),
                                   YF_W'(w_ymin_fin >> SHIFT), YF_W'(w_ymax_fin >> SHIFT));

    // Frame FSM with position/count tracking and registered status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_x         <= {XW{1'b0}};
            r_y         <= {YW{1'b0}};
            r_count     <= {CNT_W{1'b0}};
            r_bbox_word <= 32'd0;
            r_pix_count <= {CNT_W{1'b0}};
            r_frame_err <= 1'b0;
        end else begin
            r_ready                     <= 1'b1;
            r_bbox_word[FRAME_DONE_BIT] <= 1'b0;
            r_frame_err                 <= 1'b0;
            if (w_frame_beat) begin
                r_x     <= w_nx;
                r_y     <= w_ny;
                r_count <= w_cnt_next;
                if (w_start && (r_state == ACTIVE)) begin
                    r_frame_err <= 1'b1;
                end
                if (w_last && i_sink_eop) begin
                    r_state     <= PUBLISH;
                    r_bbox_word <= w_pub_word;
                    r_pix_count <= w_cnt_next;
                end else if (w_last || i_sink_eop) begin
                    r_state     <= ERR;
                    r_frame_err <= 1'b1;
                end else begin
                    r_state <= ACTIVE;
                end
            end else begin
                case (r_state)
                    ACTIVE:  r_state <= ACTIVE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_sink_ready = r_ready;
    assign o_bbox_word  = r_bbox_word;
    assign o_pix_count  = r_pix_count;
    assign o_frame_err  = r_frame_err;

endmodule
